// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register.
// Carries the decode control word, operands, register numbers and PC+4 into
// Execute with a latency of one cycle. It handles a branch flush, a
// downstream freeze and an optional load-use bubble, and it counts the
// bubbles it inserts.
// Optional feature: define HAZARD_DETECT_EN to enable the load-use hazard
// detector that drives stall_o.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [8:0]        id_ctrl,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_npc,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush_i,
    input  logic              freeze_i,
    output logic              stall_o,
    output logic [1:0]        ex_wb,
    output logic [2:0]        ex_m,
    output logic [3:0]        ex_ex,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_npc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Stage control rules for each clock edge, highest priority first:
    //   freeze_i : everything holds. stall_o still shows the live hazard.
    //   flush_i  : a bubble is inserted. Controls and valid are cleared. Data follows ID.
    //   hazard   : the same bubble as a flush. PC and IF/ID hold through stall_o.
    //   normal   : ID is copied into EX. Controls are gated by id_valid.
    // A flush together with a hazard inserts one bubble, and stall_o is dropped
    // because the instruction being held is squashed.

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic       hazard;
    logic       bubble;
    logic [1:0] id_wb;
    logic [2:0] id_m;
    logic [3:0] id_ex;

    // Split the control word into the groups that each later stage uses
    always_comb begin
        id_wb = {id_ctrl[5], id_ctrl[6]};              // RegWrite, MemtoReg
        id_m  = {id_ctrl[2], id_ctrl[4], id_ctrl[3]};  // Branch, MemRead, MemWrite
        id_ex = {id_ctrl[8], id_ctrl[1:0], id_ctrl[7]}; // RegDst, ALUOp, ALUSrc
    end

`ifdef HAZARD_DETECT_EN
    // Load-use detection: the load in EX targets a register that ID reads
    always_comb begin
        hazard = ex_m[1] & ex_valid & id_valid & (ex_rt != '0)
               & ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~flush_i;
    end
`else
    // Hazard detection is not built in, so the stage never stalls
    always_comb begin
        hazard = 1'b0;
    end
`endif

    // A bubble comes from a flush or a hazard and is counted once
    always_comb begin
        stall_o = hazard;
        bubble  = flush_i | hazard;
    end

    // Pipeline register and saturating bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_wb      <= '0;
            ex_m       <= '0;
            ex_ex      <= '0;
            ex_valid   <= 1'b0;
            ex_npc     <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            bubble_cnt <= '0;
        end else if (!freeze_i) begin
            ex_npc <= id_npc;
            ex_rd1 <= id_rd1;
            ex_rd2 <= id_rd2;
            ex_imm <= id_imm;
            ex_rs  <= id_rs;
            ex_rt  <= id_rt;
            ex_rd  <= id_rd;
            if (bubble) begin
                ex_wb    <= '0;
                ex_m     <= '0;
                ex_ex    <= '0;
                ex_valid <= 1'b0;
                if (bubble_cnt != CNT_MAX) begin
                    bubble_cnt <= bubble_cnt + 1'b1;
                end
            end else begin
                ex_valid <= id_valid;
                ex_wb    <= id_valid ? id_wb : 2'b00;
                ex_m     <= id_valid ? id_m  : 3'b000;
                ex_ex    <= id_valid ? id_ex : 4'b0000;
            end
        end
    end

endmodule
